// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU opcodes, MDU op encodings and MDU sequencer state encoding
//
// Purpose : common constants and types for the execute stage and the
//           multiply/divide sequencer that borrows the shared ALU.
// Contents: ALU opcode constants, MDU op enum and decode helpers,
//           3-bit MDU sequencer state enum.
package mips_pkg;

  // Shared ALU opcodes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Multiply/divide operations: bit 1 selects divide, bit 0 selects signed
  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    MDU_ST_IDLE = 3'd0,
    MDU_ST_PREP = 3'd1,
    MDU_ST_LOOP = 3'd2,
    MDU_ST_FIX  = 3'd3,
    MDU_ST_DONE = 3'd4
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic mdu_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - combinational magnitude and sign-restore helpers for the MDU
//
// Purpose : takes operand magnitudes before the iteration and restores
//           result signs afterwards. Purely combinational.
// Ports   : is_signed_i        - take magnitudes of a_i/b_i when set
//           a_i, b_i           - raw operands
//           abs_a_o, abs_b_o   - operand magnitudes (raw value when unsigned)
//           neg_q_i, neg_r_i   - negate quotient / remainder
//           q_i, r_i, q_o, r_o - quotient / remainder in and out
//           neg_p_i            - negate 64-bit product
//           p_i, p_o           - product in and out
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic           is_signed_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   abs_a_o,
  output logic [W-1:0]   abs_b_o,
  input  logic           neg_q_i,
  input  logic           neg_r_i,
  input  logic [W-1:0]   q_i,
  input  logic [W-1:0]   r_i,
  output logic [W-1:0]   q_o,
  output logic [W-1:0]   r_o,
  input  logic           neg_p_i,
  input  logic [2*W-1:0] p_i,
  output logic [2*W-1:0] p_o
);

  // The most negative value maps onto itself, which is still the correct
  // unsigned magnitude for the iteration.
  assign abs_a_o = (is_signed_i && a_i[W-1]) ? -a_i : a_i;
  assign abs_b_o = (is_signed_i && b_i[W-1]) ? -b_i : b_i;

  assign q_o = neg_q_i ? -q_i : q_i;
  assign r_o = neg_r_i ? -r_i : r_i;
  assign p_o = neg_p_i ? -p_i : p_i;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// rtl/mdu_seq_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the shared ALU
//
// Purpose : shift-add multiply and restoring divide, one iteration per
//           clock, using the execute-stage ALU for the add/subtract.
//           The ALU operand mux in the datapath selects on busy.
// Ports   : clk, reset          - clock, async active-high reset
//           start, op, a, b     - request pulse, operation, rs, rt
//           busy, done          - pipeline stall, one-cycle completion pulse
//           hi, lo              - result registers
//           alu_a/alu_b/alu_op  - shared ALU operands and opcode
//           alu_result          - shared ALU combinational result
module mdu_seq_ctrl
  import mips_pkg::*;
#(
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  // acc_hi: P_hi (multiply) or R (divide); acc_lo: P_lo or Q; m: M or D
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div;
  logic             div_by_zero;
  logic [WIDTH-1:0] div_sh;
  logic             div_ge;
  logic             mul_carry;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [2*WIDTH-1:0] p_fix;

  assign is_div      = mdu_is_div(op_q);
  assign div_by_zero = is_div && (opb_q == '0);
  assign div_sh      = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
  // R[31] set means the shifted remainder exceeds 32 bits and is certainly >= D
  assign div_ge      = acc_hi_q[WIDTH-1] | (div_sh >= m_q);
  // The ALU has no carry output; an unsigned wrap on ADD shows as result < P_hi
  assign mul_carry   = (alu_result < acc_hi_q);

  mdu_sign_fix #(.W(WIDTH)) u_sign_fix (
    .is_signed_i (mdu_is_signed(op_q)),
    .a_i         (opa_q),
    .b_i         (opb_q),
    .abs_a_o     (abs_a),
    .abs_b_o     (abs_b),
    .neg_q_i     (sq_q),
    .neg_r_i     (sr_q),
    .q_i         (acc_lo_q),
    .r_i         (acc_hi_q),
    .q_o         (q_fix),
    .r_o         (r_fix),
    .neg_p_i     (sq_q),
    .p_i         ({acc_hi_q, acc_lo_q}),
    .p_o         (p_fix)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MDU_ST_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sq_q     <= sq_d;
      sr_q     <= sr_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_ST_IDLE: if (start) state_d = MDU_ST_PREP;
      MDU_ST_PREP: state_d = div_by_zero ? MDU_ST_DONE : MDU_ST_LOOP;
      MDU_ST_LOOP: if (count_q == CNT_LAST) state_d = MDU_ST_FIX;
      MDU_ST_FIX:  state_d = MDU_ST_DONE;
      MDU_ST_DONE: state_d = MDU_ST_IDLE;
      default:     state_d = MDU_ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sq_d     = sq_q;
    sr_d     = sr_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MDU_ST_IDLE: begin
        if (start) begin
          op_d  = op;
          opa_d = a;
          opb_d = b;
        end
      end
      MDU_ST_PREP: begin
        sq_d    = mdu_is_signed(op_q) & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
        sr_d    = mdu_is_signed(op_q) & opa_q[WIDTH-1];
        count_d = '0;
        if (div_by_zero) begin
          hi_d = opa_q;
          lo_d = DIV0_LO;
        end else if (is_div) begin
          acc_hi_d = '0;
          acc_lo_d = abs_a;
          m_d      = abs_b;
        end else begin
          acc_hi_d = '0;
          acc_lo_d = abs_b;
          m_d      = abs_a;
        end
      end
      MDU_ST_LOOP: begin
        count_d = count_q + 1'b1;
        if (is_div) begin
          acc_hi_d = div_ge ? alu_result : div_sh;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_carry, alu_result, acc_lo_q[WIDTH-1:1]};
        end
      end
      MDU_ST_FIX: begin
        if (is_div) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else begin
          {hi_d, lo_d} = p_fix;
        end
      end
      default: ;
    endcase
  end

  // Outputs; the ALU sees neutral operands whenever it is not iterating
  always_comb begin
    busy   = (state_q != MDU_ST_IDLE);
    done   = (state_q == MDU_ST_DONE);
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (state_q == MDU_ST_LOOP) begin
      if (is_div) begin
        alu_a  = div_sh;
        alu_b  = m_q;
        alu_op = ALU_SUB;
      end else begin
        alu_a  = acc_hi_q;
        alu_b  = acc_lo_q[0] ? m_q : '0;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
